// File: rtl/if_id_hazard_ctrl_if.sv
// IF/ID hazard-control bus: stall/flush requests and fetched words in,
// IF/ID register contents, stall actions and stall statistics out.
interface if_id_hazard_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr_if;
  logic [DATA_W-1:0] pc_plus4_if;
  logic              pc_if_write;
  logic              bubble_ex;
  logic [DATA_W-1:0] instr_id;
  logic [DATA_W-1:0] pc_plus4_id;
  logic              valid_id;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_timeout;

  modport master (
    output stall, flush, instr_if, pc_plus4_if,
    input  pc_if_write, bubble_ex, instr_id, pc_plus4_id, valid_id,
           state_o, stall_cnt, stall_timeout
  );

  modport slave (
    input  stall, flush, instr_if, pc_plus4_if,
    output pc_if_write, bubble_ex, instr_id, pc_plus4_id, valid_id,
           state_o, stall_cnt, stall_timeout
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with load-use stall / branch flush handling,
// a saturating stall performance counter and a sticky stall-length watchdog.
module if_id_hazard_ctrl #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}},
  parameter int                MAX_STALL = 8,
  parameter int                CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  if_id_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_FLUSHED = 2'd2
  } state_t;

  localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);

  state_t            r_state;
  logic [DATA_W-1:0] r_instr_id;
  logic [DATA_W-1:0] r_pc_plus4_id;
  logic              r_valid_id;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [7:0]        r_consec;
  logic              r_timeout;

  logic              w_pc_write;
  logic              w_bubble;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [7:0]        w_consec_nxt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc_cnt = v;
    end else begin
      sat_inc_cnt = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [7:0] sat_inc_consec(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc_consec = v;
    end else begin
      sat_inc_consec = v + 8'd1;
    end
  endfunction

  // Zero-latency stall actions; flush wins so a squashed slot never bubbles.
  always_comb begin
    w_pc_write   = bus.flush | ~bus.stall;
    w_bubble     = bus.stall & ~bus.flush;
    w_cnt_nxt    = sat_inc_cnt(r_stall_cnt);
    w_consec_nxt = sat_inc_consec(r_consec);
  end

  // Pipeline register, FSM, counters and watchdog share one priority chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_instr_id    <= NOP_INSTR;
      r_pc_plus4_id <= {DATA_W{1'b0}};
      r_valid_id    <= 1'b0;
      r_stall_cnt   <= {CNT_W{1'b0}};
      r_consec      <= 8'd0;
      r_timeout     <= 1'b0;
    end else if (bus.flush) begin
      r_state       <= ST_FLUSHED;
      r_instr_id    <= NOP_INSTR;
      r_pc_plus4_id <= bus.pc_plus4_if;
      r_valid_id    <= 1'b0;
      r_consec      <= 8'd0;
    end else if (bus.stall) begin
      r_state     <= ST_HOLD;
      r_stall_cnt <= w_cnt_nxt;
      r_consec    <= w_consec_nxt;
      if (w_consec_nxt >= MAX_STALL_W) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
    end else begin
      r_state       <= ST_RUN;
      r_instr_id    <= bus.instr_if;
      r_pc_plus4_id <= bus.pc_plus4_if;
      r_valid_id    <= 1'b1;
      r_consec      <= 8'd0;
    end
  end

  assign bus.pc_if_write   = w_pc_write;
  assign bus.bubble_ex     = w_bubble;
  assign bus.instr_id      = r_instr_id;
  assign bus.pc_plus4_id   = r_pc_plus4_id;
  assign bus.valid_id      = r_valid_id;
  assign bus.state_o       = r_state;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.stall_timeout = r_timeout;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl: main instance with defaults plus a
// CNT_W=2 instance used to reach counter saturation quickly.
module tb_if_id_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_cnt;

  if_id_hazard_ctrl_if #(.DATA_W(32), .CNT_W(16)) b  ();
  if_id_hazard_ctrl_if #(.DATA_W(32), .CNT_W(2))  b2 ();

  if_id_hazard_ctrl #(.DATA_W(32), .NOP_INSTR(32'h0), .MAX_STALL(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  if_id_hazard_ctrl #(.DATA_W(32), .NOP_INSTR(32'h0), .MAX_STALL(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; b.stall = 1'b0; b.flush = 1'b0;
    b.instr_if = 32'hDEAD_BEEF; b.pc_plus4_if = 32'h0000_0F00;
    b2.stall = 1'b0; b2.flush = 1'b0; b2.instr_if = 32'h0; b2.pc_plus4_if = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b.instr_id !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=%h", b.instr_id, 32'h0); end
    total++; if (b.pc_plus4_id !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", b.pc_plus4_id, 32'h0); end
    total++; if (b.valid_id !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", b.valid_id); end
    total++; if (b.state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", b.state_o); end
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", b.stall_cnt); end
    total++; if (b.stall_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", b.stall_timeout); end
    total++; if (b.pc_if_write !== 1'b1) begin bad++; $display("FAIL rst_pcw got=%b exp=1", b.pc_if_write); end
    // Stall while in reset: comb outputs follow, registers must not react.
    b.stall = 1'b1;
    #1;
    total++; if (b.pc_if_write !== 1'b0 || b.bubble_ex !== 1'b1) begin bad++; $display("FAIL rst_comb_stall got pcw=%b bub=%b exp pcw=0 bub=1", b.pc_if_write, b.bubble_ex); end
    step(); step();
    total++; if (b.stall_cnt !== 16'd0 || b.state_o !== 2'd0 || b.instr_id !== 32'h0) begin bad++; $display("FAIL rst_no_react got cnt=%0d st=%0d instr=%h exp 0/0/0", b.stall_cnt, b.state_o, b.instr_id); end
    b.stall = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_run();
    logic [31:0] instrs [3];
    logic [31:0] pcs [3];
    instrs[0] = 32'h0000_00A1; instrs[1] = 32'h0000_00B2; instrs[2] = 32'h0000_00C3;
    pcs[0] = 32'h0000_0104; pcs[1] = 32'h0000_0108; pcs[2] = 32'h0000_010C;
    for (int i = 0; i < 3; i++) begin
      b.instr_if = instrs[i]; b.pc_plus4_if = pcs[i];
      #1;
      total++; if (b.pc_if_write !== 1'b1 || b.bubble_ex !== 1'b0) begin bad++; $display("FAIL run_comb%0d got pcw=%b bub=%b exp 1/0", i, b.pc_if_write, b.bubble_ex); end
      step();
      total++; if (b.instr_id !== instrs[i] || b.pc_plus4_id !== pcs[i]) begin bad++; $display("FAIL run_reg%0d got instr=%h pc=%h exp instr=%h pc=%h", i, b.instr_id, b.pc_plus4_id, instrs[i], pcs[i]); end
      total++; if (b.valid_id !== 1'b1 || b.state_o !== 2'd0) begin bad++; $display("FAIL run_vs%0d got valid=%b st=%0d exp 1/0", i, b.valid_id, b.state_o); end
    end
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL run_cnt got=%0d exp=0", b.stall_cnt); end
  endtask

  task automatic test_stall();
    b.instr_if = 32'h0000_00A1; b.pc_plus4_if = 32'h0000_0204; step();
    b.instr_if = 32'h0000_00B2; b.pc_plus4_if = 32'h0000_0208; step();
    b.stall = 1'b1; b.instr_if = 32'h0000_00C3; b.pc_plus4_if = 32'h0000_020C;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (b.bubble_ex !== 1'b1 || b.pc_if_write !== 1'b0) begin bad++; $display("FAIL stall_comb%0d got bub=%b pcw=%b exp 1/0", i, b.bubble_ex, b.pc_if_write); end
      step();
      exp_cnt++;
      total++; if (b.instr_id !== 32'h0000_00B2 || b.pc_plus4_id !== 32'h0000_0208 || b.valid_id !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got instr=%h pc=%h v=%b exp b2/208/1", i, b.instr_id, b.pc_plus4_id, b.valid_id); end
      total++; if (b.state_o !== 2'd1) begin bad++; $display("FAIL stall_state%0d got=%0d exp=1", i, b.state_o); end
    end
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", b.stall_cnt, exp_cnt); end
    b.stall = 1'b0; step();
    total++; if (b.instr_id !== 32'h0000_00C3 || b.state_o !== 2'd0 || b.valid_id !== 1'b1) begin bad++; $display("FAIL stall_resume got instr=%h st=%0d v=%b exp c3/0/1", b.instr_id, b.state_o, b.valid_id); end
  endtask

  task automatic test_flush();
    b.stall = 1'b1; b.flush = 1'b1; b.instr_if = 32'h0000_00D4; b.pc_plus4_if = 32'h0000_0304;
    #1;
    total++; if (b.pc_if_write !== 1'b1 || b.bubble_ex !== 1'b0) begin bad++; $display("FAIL flush_comb got pcw=%b bub=%b exp 1/0", b.pc_if_write, b.bubble_ex); end
    step();
    total++; if (b.instr_id !== 32'h0 || b.valid_id !== 1'b0 || b.state_o !== 2'd2) begin bad++; $display("FAIL flush_reg got instr=%h v=%b st=%0d exp 0/0/2", b.instr_id, b.valid_id, b.state_o); end
    total++; if (b.pc_plus4_id !== 32'h0000_0304) begin bad++; $display("FAIL flush_pc got=%h exp=304", b.pc_plus4_id); end
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", b.stall_cnt, exp_cnt); end
    // Back-to-back flush keeps FLUSHED, then a normal edge returns to RUN.
    b.stall = 1'b0; b.pc_plus4_if = 32'h0000_0308; step();
    total++; if (b.state_o !== 2'd2 || b.pc_plus4_id !== 32'h0000_0308) begin bad++; $display("FAIL flush_b2b got st=%0d pc=%h exp 2/308", b.state_o, b.pc_plus4_id); end
    b.flush = 1'b0; b.instr_if = 32'h0000_00E5; b.pc_plus4_if = 32'h0000_030C; step();
    total++; if (b.state_o !== 2'd0 || b.instr_id !== 32'h0000_00E5 || b.valid_id !== 1'b1) begin bad++; $display("FAIL flush_exit got st=%0d instr=%h v=%b exp 0/e5/1", b.state_o, b.instr_id, b.valid_id); end
  endtask

  task automatic test_watchdog();
    b.stall = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_cnt++;
      total++; if (b.stall_timeout !== (i == 8)) begin bad++; $display("FAIL wd_edge%0d got=%b exp=%b", i, b.stall_timeout, (i == 8)); end
    end
    b.stall = 1'b0; step(); step();
    total++; if (b.stall_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", b.stall_timeout); end
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL wd_cnt got=%0d exp=%0d", b.stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    rst_n = 1'b0; #2 rst_n = 1'b1;
    b.instr_if = 32'h0000_00F6; b.pc_plus4_if = 32'h0000_0404; step();
    b.stall = 1'b1; step(); step(); step();
    total++; if (b.stall_cnt !== 16'd3) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=3", b.stall_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (b.stall_cnt !== 16'd0 || b.instr_id !== 32'h0 || b.pc_plus4_id !== 32'h0) begin bad++; $display("FAIL mid_async got cnt=%0d instr=%h pc=%h exp 0/0/0", b.stall_cnt, b.instr_id, b.pc_plus4_id); end
    total++; if (b.valid_id !== 1'b0 || b.state_o !== 2'd0 || b.stall_timeout !== 1'b0) begin bad++; $display("FAIL mid_async2 got v=%b st=%0d to=%b exp 0/0/0", b.valid_id, b.state_o, b.stall_timeout); end
    b.stall = 1'b0; b.instr_if = 32'h0000_0017; b.pc_plus4_if = 32'h0000_0504;
    rst_n = 1'b1;
    step();
    total++; if (b.instr_id !== 32'h0000_0017 || b.state_o !== 2'd0 || b.valid_id !== 1'b1) begin bad++; $display("FAIL mid_release got instr=%h st=%0d v=%b exp 17/0/1", b.instr_id, b.state_o, b.valid_id); end
    // Consecutive count restarted: 7 stalls must not trip the watchdog.
    b.stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    b.stall = 1'b0; step();
    total++; if (b.stall_timeout !== 1'b0 || b.stall_cnt !== 16'd7) begin bad++; $display("FAIL mid_consec got to=%b cnt=%0d exp 0/7", b.stall_timeout, b.stall_cnt); end
  endtask

  task automatic test_saturate();
    b2.stall = 1'b1;
    step(); step(); step();
    total++; if (b2.stall_cnt !== 2'b11) begin bad++; $display("FAIL sat_full got=%0d exp=3", b2.stall_cnt); end
    step();
    total++; if (b2.stall_cnt !== 2'b11) begin bad++; $display("FAIL sat_nowrap got=%0d exp=3", b2.stall_cnt); end
    b2.stall = 1'b0; step();
    total++; if (b2.stall_cnt !== 2'b11 || b2.stall_timeout !== 1'b0) begin bad++; $display("FAIL sat_after got cnt=%0d to=%b exp 3/0", b2.stall_cnt, b2.stall_timeout); end
  endtask

  initial begin
    clk = 1'b0;
    total = 0;
    bad = 0;
    exp_cnt = 0;
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_watchdog();
    test_reset_mid_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
